// File: rtl/wb_cmd_master.sv
// wb_cmd_master: turns single / incrementing multi-beat commands into
// Wishbone classic single cycles, returning one response per beat.
//
// Ports:
//   wb_clk_i, wb_rst_i            clock, synchronous active-high reset
//   cmd_*                         command stream (valid/ready)
//   wdat_*                        write data beats (valid/ready)
//   rsp_*                         per-beat responses (valid/ready)
//   busy                          FSM not idle
//   wbm_*                         Wishbone master side
//
// Optional: define WBM_TIMEOUT_EN to abort a beat whose strobe has been
// held TIMEOUT_CYC cycles without ack (rsp_err=1, remaining beats dropped).
module wb_cmd_master #(
  parameter int LEN_W       = 8,
  parameter int ADR_INC     = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_adr,
  input  logic [3:0]       cmd_sel,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wdat_valid,
  output logic             wdat_ready,
  input  logic [31:0]      wdat,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_err,
  output logic             rsp_last,
  output logic             busy,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i
);

  typedef enum logic [1:0] {
    IDLE,
    WDAT,
    BUS,
    RESP
  } state_t;

  state_t           state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] beat;

  if (TIMEOUT_CYC < 1) begin : g_bad_tmo
    $error("wb_cmd_master: TIMEOUT_CYC must be >= 1");
  end

  // Handshake readies are masked while reset is held so that nothing
  // can be accepted on the very edge that clears the FSM.
  assign cmd_ready  = (state == IDLE) && !wb_rst_i;
  assign wdat_ready = (state == WDAT) && !wb_rst_i;
  assign busy       = (state != IDLE);

`ifdef WBM_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;

  logic [TW-1:0] tmo_q;
  logic          err_q;

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      len_q     <= '0;
      beat      <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_last  <= 1'b0;
`ifdef WBM_TIMEOUT_EN
      tmo_q     <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            wbm_we_o  <= cmd_we;
            wbm_adr_o <= cmd_adr;
            wbm_sel_o <= cmd_sel;
            len_q     <= cmd_len;
            beat      <= '0;
            if (cmd_we) begin
              state <= WDAT;
            end else begin
              state     <= BUS;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
`ifdef WBM_TIMEOUT_EN
              tmo_q     <= '0;
`endif
            end
          end
        end
        WDAT: begin
          if (wdat_valid) begin
            wbm_dat_o <= wdat;
            state     <= BUS;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
`ifdef WBM_TIMEOUT_EN
            tmo_q     <= '0;
`endif
          end
        end
        BUS: begin
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_data  <= wbm_we_o ? 32'd0 : wbm_dat_i;
            rsp_last  <= (beat == len_q);
            rsp_valid <= 1'b1;
            state     <= RESP;
`ifdef WBM_TIMEOUT_EN
            err_q     <= 1'b0;
          end else if (tmo_q == TW'(TIMEOUT_CYC - 1)) begin
            // This cycle is the TIMEOUT_CYC-th without ack.
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            rsp_data  <= '0;
            rsp_last  <= 1'b1;
            rsp_valid <= 1'b1;
            err_q     <= 1'b1;
            state     <= RESP;
          end else begin
            tmo_q <= tmo_q + TW'(1);
`endif
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_last  <= 1'b0;
            if (rsp_last) begin
              state <= IDLE;
            end else begin
              wbm_adr_o <= wbm_adr_o + 32'(ADR_INC);
              beat      <= beat + LEN_W'(1);
              if (wbm_we_o) begin
                state <= WDAT;
              end else begin
                state     <= BUS;
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
`ifdef WBM_TIMEOUT_EN
                tmo_q     <= '0;
`endif
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: directed table, hand sequences and random commands
// against a transaction-level model of the command/bus/response streams.
module tb_wb_cmd_master;

  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr;
  logic [3:0]  cmd_sel;
  logic [7:0]  cmd_len;
  logic        wdat_valid, wdat_ready;
  logic [31:0] wdat;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err, rsp_last, busy;
  logic        cyc, stb, we_o;
  logic [3:0]  sel_o;
  logic [31:0] adr_o, dat_o;
  logic        ack;
  logic [31:0] dat_i;

  int checks = 0;
  int errors = 0;

  int ack_dly   = 0;
  bit never_ack = 0;
  bit junk_ack  = 0;
  int last_win  = 0;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] dat;
    int          win;
  } beat_t;

  beat_t bus_q[$];

  always #5 clk = ~clk;

  wb_cmd_master dut (
    .wb_clk_i   (clk),
    .wb_rst_i   (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_adr    (cmd_adr),
    .cmd_sel    (cmd_sel),
    .cmd_len    (cmd_len),
    .wdat_valid (wdat_valid),
    .wdat_ready (wdat_ready),
    .wdat       (wdat),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_err    (rsp_err),
    .rsp_last   (rsp_last),
    .busy       (busy),
    .wbm_cyc_o  (cyc),
    .wbm_stb_o  (stb),
    .wbm_we_o   (we_o),
    .wbm_sel_o  (sel_o),
    .wbm_adr_o  (adr_o),
    .wbm_dat_o  (dat_o),
    .wbm_ack_i  (ack),
    .wbm_dat_i  (dat_i)
  );

  // Slave memory contents as a pure function of the address.
  function automatic logic [31:0] rd_fn(input logic [31:0] a);
    return a ^ 32'hEEAD_BEEB;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Wishbone slave: acks ack_dly cycles after strobe rises, logs beats.
  initial begin
    int run;
    bit prev_stb;
    bit prev_real;
    run = 0;
    prev_stb = 0;
    prev_real = 0;
    ack = 0;
    dat_i = 0;
    forever begin
      @(posedge clk);
      #1;
      if (prev_real) chk("cyc_gap", {30'd0, cyc, stb}, 32'd0);
      if (stb) begin
        if (!prev_stb || prev_real) run = 0;
        run++;
        if (!never_ack && run == ack_dly + 1) begin
          ack = 1;
          dat_i = rd_fn(adr_o);
          bus_q.push_back(beat_t'{adr_o, we_o, sel_o, dat_o, run});
        end else begin
          ack = 0;
          dat_i = $urandom;
        end
      end else begin
        if (prev_stb) last_win = run;
        run = 0;
        ack = junk_ack && ($urandom_range(3) == 0);
        dat_i = $urandom;
      end
      prev_real = stb && ack;
      prev_stb = stb;
    end
  end

  // One full command against the model: beat i goes to adr+4*i, reads
  // return rd_fn, writes return 0, last only on beat len.
  task automatic run_cmd(input bit we, input logic [31:0] adr,
                         input logic [3:0] sel, input int len,
                         input int dly, input int hold, input bit rnd,
                         input logic [31:0] wd[$],
                         output logic [31:0] d0);
    int wi;
    int ri;
    int held;
    int n;
    bit pend;
    bit hs_c;
    logic [31:0] ea;
    wi = 0;
    ri = 0;
    held = 0;
    n = 0;
    pend = 1;
    d0 = 32'hx;
    bus_q.delete();
    ack_dly = dly;
    cmd_we = we;
    cmd_adr = adr;
    cmd_sel = sel;
    cmd_len = len[7:0];
    while (ri <= len) begin
      if (n++ > 3000) begin
        checks++;
        errors++;
        $display("FAIL cmd_budget: got %0d rsp want %0d", ri, len + 1);
        break;
      end
      cmd_valid = pend;
      wdat_valid = we && (wi <= len) && (!rnd || $urandom_range(3) != 0);
      wdat = (wi <= len) ? wd[wi] : 32'd0;
      rsp_ready = !rnd || $urandom_range(2) != 0;
      if (rsp_valid && held < hold) rsp_ready = 0;
      if (busy) chk("cmd_ready_busy", {31'd0, cmd_ready}, 32'd0);
      if (rsp_valid) begin
        ea = adr + 32'(4 * ri);
        chk("rsp_data", rsp_data, we ? 32'd0 : rd_fn(ea));
        chk("rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rsp_last", {31'd0, rsp_last}, {31'd0, ri == len});
        if (!rsp_ready) begin
          held++;
          chk("stb_in_resp", {31'd0, stb}, 32'd0);
        end else begin
          if (ri == 0) d0 = rsp_data;
          ri++;
          held = 0;
        end
      end
      if (wdat_valid && wdat_ready) begin
        chk("wdat_after_cmd", {31'd0, pend}, 32'd0);
        wi++;
      end
      hs_c = cmd_valid && cmd_ready;
      @(posedge clk);
      #1;
      if (hs_c) pend = 0;
    end
    cmd_valid = 0;
    wdat_valid = 0;
    rsp_ready = 0;
    chk("busy_end", {31'd0, busy}, 32'd0);
    chk("n_beats", bus_q.size(), len + 1);
    foreach (bus_q[i]) begin
      chk("beat_adr", bus_q[i].adr, adr + 32'(4 * i));
      chk("beat_we", {31'd0, bus_q[i].we}, {31'd0, we});
      chk("beat_sel", {28'd0, bus_q[i].sel}, {28'd0, sel});
      chk("beat_win", bus_q[i].win, dly + 1);
      if (we && i <= len) chk("beat_dat", bus_q[i].dat, wd[i]);
    end
  endtask

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [3:0]  sel;
    int          len;
    int          dly;
    int          hold;
    logic [31:0] exp_d0;
    logic [31:0] exp_last_adr;
  } vec_t;

  initial begin
    vec_t vt[5];
    logic [31:0] wd[$];
    logic [31:0] d0;
    int r;
    int n;
    int k;
    int wi;
    bit pend;
    bit hs_c;
    bit hs_w;
    bit seen;

    vt[0] = '{0, 32'h3000_0004, 4'hF, 0, 2, 0, 32'hDEAD_BEEF, 32'h3000_0004};
    vt[1] = '{1, 32'h3000_0000, 4'hF, 3, 0, 0, 32'h0000_0000, 32'h3000_000C};
    vt[2] = '{0, 32'h0000_0100, 4'h5, 1, 0, 5, 32'hEEAD_BFEB, 32'h0000_0104};
    vt[3] = '{0, 32'hFFFF_FFFC, 4'hF, 1, 1, 0, 32'h1152_4117, 32'h0000_0000};
    vt[4] = '{1, 32'h0000_0010, 4'h3, 0, 3, 2, 32'h0000_0000, 32'h0000_0010};

    rst = 1;
    cmd_valid = 0;
    cmd_we = 0;
    cmd_adr = 0;
    cmd_sel = 0;
    cmd_len = 0;
    wdat_valid = 0;
    wdat = 0;
    rsp_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ctrl", {23'd0, cmd_ready, wdat_ready, rsp_valid, rsp_err,
                     rsp_last, busy, cyc, stb, we_o}, 32'd0);
    chk("rst_sel", {28'd0, sel_o}, 32'd0);
    chk("rst_adr", adr_o, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_rdata", rsp_data, 32'd0);
    rst = 0;
    #1;
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    for (int v = 0; v < 5; v++) begin
      wd.delete();
      for (int i = 0; i <= vt[v].len; i++) wd.push_back(32'h11 * (i + 1));
      run_cmd(vt[v].we, vt[v].adr, vt[v].sel, vt[v].len, vt[v].dly,
              vt[v].hold, 0, wd, d0);
      chk("vec_d0", d0, vt[v].exp_d0);
      if (bus_q.size() > 0)
        chk("vec_last_adr", bus_q[bus_q.size() - 1].adr, vt[v].exp_last_adr);
    end

    // Reset during the 2nd beat's bus window of a 4-beat write.
    bus_q.delete();
    ack_dly = 5;
    rsp_ready = 1;
    cmd_we = 1;
    cmd_adr = 32'h3000_0000;
    cmd_sel = 4'hF;
    cmd_len = 8'd3;
    pend = 1;
    wi = 0;
    k = 0;
    n = 0;
    while (k < 2 && n < 200) begin
      n++;
      cmd_valid = pend;
      wdat_valid = (wi < 4);
      wdat = 32'h11 * (wi + 1);
      hs_c = cmd_valid && cmd_ready;
      hs_w = wdat_valid && wdat_ready;
      @(posedge clk);
      #1;
      if (hs_c) pend = 0;
      if (hs_w) wi++;
      if (bus_q.size() == 1 && stb) k++;
    end
    chk("rst_seq_reach", k, 2);
    cmd_valid = 0;
    wdat_valid = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    chk("mid_rst_bus", {30'd0, cyc, stb}, 32'd0);
    chk("mid_rst_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    #1;
    chk("mid_rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    seen = 0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (rsp_valid || stb) seen = 1;
    end
    chk("post_rst_quiet", {31'd0, seen}, 32'd0);
    chk("post_rst_beats", bus_q.size(), 1);
    rsp_ready = 0;

`ifdef WBM_TIMEOUT_EN
    never_ack = 1;
    bus_q.delete();
    cmd_we = 0;
    cmd_adr = 32'h0000_2000;
    cmd_sel = 4'hF;
    cmd_len = 8'd2;
    cmd_valid = 1;
    @(posedge clk);
    #1;
    cmd_valid = 0;
    n = 0;
    while (!rsp_valid && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("tmo_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("tmo_err", {31'd0, rsp_err}, 32'd1);
    chk("tmo_data", rsp_data, 32'd0);
    chk("tmo_last", {31'd0, rsp_last}, 32'd1);
    rsp_ready = 1;
    @(posedge clk);
    #1;
    rsp_ready = 0;
    chk("tmo_busy", {31'd0, busy}, 32'd0);
    chk("tmo_win", last_win, TMO);
    chk("tmo_beats", bus_q.size(), 0);
    seen = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (rsp_valid || stb) seen = 1;
    end
    chk("tmo_single_rsp", {31'd0, seen}, 32'd0);
    never_ack = 0;
    wd.delete();
    wd.push_back(32'd0);
    run_cmd(vt[0].we, vt[0].adr, vt[0].sel, vt[0].len, vt[0].dly, 0, 0,
            wd, d0);
    chk("tmo_next_d0", d0, vt[0].exp_d0);
`endif

    // Random commands with stray acks, gappy data and back-pressure.
    junk_ack = 1;
    for (int t = 0; t < 40; t++) begin
      logic        rwe;
      logic [31:0] radr;
      logic [3:0]  rsel;
      int          rlen;
      r = $urandom;
      radr = (t % 8 == 0) ? 32'hFFFF_FFF4 : (r & 32'hFFFF_FFFC);
      rwe = 1'($urandom_range(1));
      rsel = 4'($urandom_range(15));
      rlen = $urandom_range(4);
      wd.delete();
      for (int i = 0; i <= rlen; i++) wd.push_back($urandom);
      run_cmd(rwe, radr, rsel, rlen, $urandom_range(3), $urandom_range(2),
              1, wd, d0);
    end
    junk_ack = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

endmodule
